// File: rtl/mpsoc_pkg.sv
// Shared MPSoC bus encodings (AHB-Lite transfer, size, burst and response codes).
package mpsoc_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'b000,
        HSIZE_HWORD = 3'b001,
        HSIZE_WORD  = 3'b010,
        HSIZE_DWORD = 3'b011
    } hsize_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011
    } hburst_e;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;

endpackage

// File: rtl/mpsoc_wb2ahb_bridge_pkg.sv
// Bridge-private types: FSM state and the fixed protection attribute it drives.
package mpsoc_wb2ahb_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10,
        ST_RESP = 2'b11
    } state_e;

    // Privileged data access, non-bufferable, non-cacheable.
    localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

endpackage

// File: rtl/mpsoc_wb2ahb_bridge_if.sv
// Wishbone classic slave port plus AHB-Lite master port of the bridge.
// slave: the bridge's view; master: the Wishbone requester and AHB target side.
interface mpsoc_wb2ahb_bridge_if #(
    parameter int HADDR_SIZE = 64,
    parameter int HDATA_SIZE = 32
);
    localparam int BE_SIZE = HDATA_SIZE / 8;

    logic                  wb_cyc_i;
    logic                  wb_stb_i;
    logic                  wb_we_i;
    logic [HADDR_SIZE-1:0] wb_adr_i;
    logic [HDATA_SIZE-1:0] wb_dat_i;
    logic [BE_SIZE-1:0]    wb_sel_i;
    logic [HDATA_SIZE-1:0] wb_dat_o;
    logic                  wb_ack_o;
    logic                  wb_err_o;

    logic                  HSEL;
    logic                  HWRITE;
    logic                  HMASTLOCK;
    logic [HADDR_SIZE-1:0] HADDR;
    logic [HDATA_SIZE-1:0] HWDATA;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [3:0]            HPROT;
    logic [1:0]            HTRANS;
    logic [HDATA_SIZE-1:0] HRDATA;
    logic                  HREADY;
    logic                  HRESP;

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        output wb_dat_o, wb_ack_o, wb_err_o,
        output HSEL, HWRITE, HMASTLOCK, HADDR, HWDATA, HSIZE, HBURST, HPROT, HTRANS,
        input  HRDATA, HREADY, HRESP
    );

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        input  wb_dat_o, wb_ack_o, wb_err_o,
        input  HSEL, HWRITE, HMASTLOCK, HADDR, HWDATA, HSIZE, HBURST, HPROT, HTRANS,
        output HRDATA, HREADY, HRESP
    );

endinterface

// File: rtl/mpsoc_wb2ahb_sel_decode.sv
// Byte-select decode: legal selects are a naturally aligned power-of-two run of ones.
module mpsoc_wb2ahb_sel_decode
    import mpsoc_pkg::*;
#(
    parameter int BE_SIZE = 4,
    parameter int OFF_W   = $clog2(BE_SIZE)
) (
    input  logic [BE_SIZE-1:0] sel,
    output hsize_e             size,
    output logic [OFF_W-1:0]   offset,
    output logic               illegal
);

    logic [3:0]         lo_s;
    logic [3:0]         cnt_s;
    logic               found_s;
    logic [BE_SIZE-1:0] mask_s;
    hsize_e             size_s;
    logic               size_ok_s;
    logic               aligned_s;

    // Lowest set index and population count of the select vector.
    always_comb begin
        lo_s    = 4'd0;
        cnt_s   = 4'd0;
        found_s = 1'b0;
        for (int i = 0; i < BE_SIZE; i++) begin
            lo_s    = (sel[i] && !found_s) ? 4'(i) : lo_s;
            found_s = found_s | sel[i];
            cnt_s   = cnt_s + {3'd0, sel[i]};
        end
    end

    // Contiguous run implied by lo/cnt; equals sel only when sel has no holes.
    always_comb begin
        mask_s = {BE_SIZE{1'b0}};
        for (int i = 0; i < BE_SIZE; i++) begin
            mask_s[i] = (4'(i) >= lo_s) && (4'(i) < (lo_s + cnt_s));
        end
    end

    // Map the byte count onto a transfer size.
    always_comb begin
        size_s    = HSIZE_BYTE;
        size_ok_s = 1'b1;
        case (cnt_s)
            4'd1:    size_s = HSIZE_BYTE;
            4'd2:    size_s = HSIZE_HWORD;
            4'd4:    size_s = HSIZE_WORD;
            4'd8:    size_s = HSIZE_DWORD;
            default: begin
                size_s    = HSIZE_BYTE;
                size_ok_s = 1'b0;
            end
        endcase
    end

    assign aligned_s = ((lo_s & (cnt_s - 4'd1)) == 4'd0);
    assign illegal   = ~(size_ok_s & (mask_s == sel) & aligned_s);
    assign size      = size_s;
    assign offset    = lo_s[OFF_W-1:0];

endmodule

// File: rtl/mpsoc_wb2ahb_bridge.sv
// Wishbone classic slave to AHB-Lite single-transfer master, one transfer in flight.
module mpsoc_wb2ahb_bridge
    import mpsoc_pkg::*;
    import mpsoc_wb2ahb_bridge_pkg::*;
#(
    parameter int HADDR_SIZE = 64,
    parameter int HDATA_SIZE = 32
) (
    input logic                  HCLK,
    input logic                  HRESET,
    mpsoc_wb2ahb_bridge_if.slave bus
);

    localparam int BE_SIZE = HDATA_SIZE / 8;
    localparam int OFF_W   = $clog2(BE_SIZE);

    state_e                state_r, next_state_s;
    logic                  hsel_r, hsel_s;
    logic                  hwrite_r, hwrite_s;
    logic [HADDR_SIZE-1:0] haddr_r, haddr_s;
    logic [HDATA_SIZE-1:0] hwdata_r, hwdata_s;
    logic [HDATA_SIZE-1:0] wdat_r, wdat_s;
    hsize_e                hsize_r, hsize_s;
    htrans_e               htrans_r, htrans_s;
    logic                  ack_r, ack_s;
    logic                  err_r, err_s;
    logic [HDATA_SIZE-1:0] dat_r, dat_s;
    logic                  cyc_lost_r, cyc_lost_s;

    hsize_e                dec_size_s;
    logic [OFF_W-1:0]      dec_offset_s;
    logic                  dec_illegal_s;
    logic                  req_s;
    logic                  lost_s;
    logic                  unused_adr_s;

    mpsoc_wb2ahb_sel_decode #(
        .BE_SIZE (BE_SIZE)
    ) u_sel_decode (
        .sel     (bus.wb_sel_i),
        .size    (dec_size_s),
        .offset  (dec_offset_s),
        .illegal (dec_illegal_s)
    );

    assign req_s        = bus.wb_cyc_i & bus.wb_stb_i;
    // A requester that drops cyc mid-transfer no longer wants a termination.
    assign lost_s       = cyc_lost_r | ~bus.wb_cyc_i;
    assign unused_adr_s = ^bus.wb_adr_i[OFF_W-1:0];

    // FSM state register.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_s && dec_illegal_s) begin
                    next_state_s = ST_RESP;
                end else if (req_s) begin
                    next_state_s = ST_ADDR;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (bus.HREADY) begin
                    next_state_s = ST_DATA;
                end else begin
                    next_state_s = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (bus.HREADY && lost_s) begin
                    next_state_s = ST_IDLE;
                end else if (bus.HREADY) begin
                    next_state_s = ST_RESP;
                end else begin
                    next_state_s = ST_DATA;
                end
            end
            ST_RESP: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // FSM output logic: next values of the registered bus outputs.
    always_comb begin
        hsel_s     = 1'b0;
        htrans_s   = HTRANS_IDLE;
        hwrite_s   = hwrite_r;
        haddr_s    = haddr_r;
        hsize_s    = hsize_r;
        hwdata_s   = hwdata_r;
        wdat_s     = wdat_r;
        dat_s      = dat_r;
        cyc_lost_s = cyc_lost_r;
        ack_s      = 1'b0;
        err_s      = 1'b0;
        if (next_state_s == ST_ADDR) begin
            hsel_s   = 1'b1;
            htrans_s = HTRANS_NONSEQ;
        end else begin
            hsel_s   = 1'b0;
            htrans_s = HTRANS_IDLE;
        end
        case (state_r)
            ST_IDLE: begin
                if (next_state_s == ST_ADDR) begin
                    haddr_s    = {bus.wb_adr_i[HADDR_SIZE-1:OFF_W], dec_offset_s};
                    hsize_s    = dec_size_s;
                    hwrite_s   = bus.wb_we_i;
                    wdat_s     = bus.wb_dat_i;
                    cyc_lost_s = 1'b0;
                end else begin
                    err_s = (next_state_s == ST_RESP);
                end
            end
            ST_ADDR: begin
                cyc_lost_s = lost_s;
                if (next_state_s == ST_DATA) begin
                    hwdata_s = wdat_r;
                end else begin
                    hwdata_s = hwdata_r;
                end
            end
            ST_DATA: begin
                cyc_lost_s = lost_s;
                if (next_state_s == ST_RESP) begin
                    ack_s = (bus.HRESP == HRESP_OKAY);
                    err_s = (bus.HRESP == HRESP_ERROR);
                    dat_s = hwrite_r ? dat_r : bus.HRDATA;
                end else begin
                    dat_s = dat_r;
                end
            end
            ST_RESP: cyc_lost_s = cyc_lost_r;
            default: cyc_lost_s = cyc_lost_r;
        endcase
    end

    // Output and request registers.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            hsel_r     <= 1'b0;
            htrans_r   <= HTRANS_IDLE;
            hwrite_r   <= 1'b0;
            haddr_r    <= {HADDR_SIZE{1'b0}};
            hsize_r    <= HSIZE_BYTE;
            hwdata_r   <= {HDATA_SIZE{1'b0}};
            wdat_r     <= {HDATA_SIZE{1'b0}};
            dat_r      <= {HDATA_SIZE{1'b0}};
            ack_r      <= 1'b0;
            err_r      <= 1'b0;
            cyc_lost_r <= 1'b0;
        end else begin
            hsel_r     <= hsel_s;
            htrans_r   <= htrans_s;
            hwrite_r   <= hwrite_s;
            haddr_r    <= haddr_s;
            hsize_r    <= hsize_s;
            hwdata_r   <= hwdata_s;
            wdat_r     <= wdat_s;
            dat_r      <= dat_s;
            ack_r      <= ack_s;
            err_r      <= err_s;
            cyc_lost_r <= cyc_lost_s;
        end
    end

    assign bus.HSEL      = hsel_r;
    assign bus.HTRANS    = htrans_r;
    assign bus.HWRITE    = hwrite_r;
    assign bus.HADDR     = haddr_r;
    assign bus.HSIZE     = hsize_r;
    assign bus.HWDATA    = hwdata_r;
    assign bus.HBURST    = HBURST_SINGLE;
    assign bus.HPROT     = HPROT_DATA_PRIV;
    assign bus.HMASTLOCK = 1'b0;
    assign bus.wb_dat_o  = dat_r;
    assign bus.wb_ack_o  = ack_r;
    assign bus.wb_err_o  = err_r;

endmodule

// File: tb/tb_mpsoc_wb2ahb_bridge.sv
// Directed bench for the Wishbone-to-AHB bridge, 32-bit data / 64-bit address.
module tb_mpsoc_wb2ahb_bridge;

    logic HCLK   = 1'b0;
    logic HRESET = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;
    logic [3:0] bad_sel [3];

    mpsoc_wb2ahb_bridge_if #(.HADDR_SIZE(64), .HDATA_SIZE(32)) bus ();

    mpsoc_wb2ahb_bridge #(
        .HADDR_SIZE (64),
        .HDATA_SIZE (32)
    ) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic we, input logic [63:0] adr, input logic [3:0] sel,
                       input logic [31:0] dat);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = we;
        bus.wb_adr_i = adr;
        bus.wb_sel_i = sel;
        bus.wb_dat_i = dat;
    endtask

    task automatic release_bus();
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
    endtask

    task automatic cyc();
        @(negedge HCLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1);
    end

    initial begin
        bad_sel[0] = 4'b0101;
        bad_sel[1] = 4'b0110;
        bad_sel[2] = 4'b0111;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        bus.wb_adr_i = 64'h0;
        bus.wb_sel_i = 4'h0;
        bus.wb_dat_i = 32'h0;
        bus.HRDATA   = 32'h0;
        bus.HREADY   = 1'b1;
        bus.HRESP    = 1'b0;
        repeat (3) cyc();

        // Reset values
        chk("rst_htrans", 64'(bus.HTRANS), 64'h0);
        chk("rst_hsel", 64'(bus.HSEL), 64'h0);
        chk("rst_hwrite", 64'(bus.HWRITE), 64'h0);
        chk("rst_haddr", bus.HADDR, 64'h0);
        chk("rst_hwdata", 64'(bus.HWDATA), 64'h0);
        chk("rst_hsize", 64'(bus.HSIZE), 64'h0);
        chk("rst_hburst", 64'(bus.HBURST), 64'h0);
        chk("rst_hprot", 64'(bus.HPROT), 64'h3);
        chk("rst_hmastlock", 64'(bus.HMASTLOCK), 64'h0);
        chk("rst_ack", 64'(bus.wb_ack_o), 64'h0);
        chk("rst_err", 64'(bus.wb_err_o), 64'h0);
        chk("rst_dat", 64'(bus.wb_dat_o), 64'h0);
        HRESET = 1'b0;
        cyc();

        // Zero-wait word write
        req(1'b1, 64'h100, 4'b1111, 32'hDEADBEEF);
        cyc();
        chk("wr_n1_htrans", 64'(bus.HTRANS), 64'h2);
        chk("wr_n1_hsel", 64'(bus.HSEL), 64'h1);
        chk("wr_n1_hsize", 64'(bus.HSIZE), 64'h2);
        chk("wr_n1_haddr", bus.HADDR, 64'h100);
        chk("wr_n1_hwrite", 64'(bus.HWRITE), 64'h1);
        chk("wr_n1_ack", 64'(bus.wb_ack_o), 64'h0);
        cyc();
        chk("wr_n2_htrans", 64'(bus.HTRANS), 64'h0);
        chk("wr_n2_hsel", 64'(bus.HSEL), 64'h0);
        chk("wr_n2_hwdata", 64'(bus.HWDATA), 64'hDEADBEEF);
        chk("wr_n2_ack", 64'(bus.wb_ack_o), 64'h0);
        cyc();
        chk("wr_n3_ack", 64'(bus.wb_ack_o), 64'h1);
        chk("wr_n3_err", 64'(bus.wb_err_o), 64'h0);
        release_bus();
        cyc();
        chk("wr_n4_ack", 64'(bus.wb_ack_o), 64'h0);

        // Upper halfword read with two data-phase wait states
        req(1'b0, 64'h104, 4'b1100, 32'h0);
        cyc();
        chk("rd_n1_htrans", 64'(bus.HTRANS), 64'h2);
        chk("rd_n1_hsize", 64'(bus.HSIZE), 64'h1);
        chk("rd_n1_haddr", bus.HADDR, 64'h106);
        chk("rd_n1_hwrite", 64'(bus.HWRITE), 64'h0);
        cyc();
        chk("rd_n2_htrans", 64'(bus.HTRANS), 64'h0);
        bus.HREADY = 1'b0;
        cyc();
        chk("rd_n3_ack", 64'(bus.wb_ack_o), 64'h0);
        cyc();
        chk("rd_n4_ack", 64'(bus.wb_ack_o), 64'h0);
        bus.HREADY = 1'b1;
        bus.HRDATA = 32'h12345678;
        cyc();
        chk("rd_n5_ack", 64'(bus.wb_ack_o), 64'h1);
        chk("rd_n5_dat", 64'(bus.wb_dat_o), 64'h12345678);
        release_bus();
        bus.HRDATA = 32'hFFFFFFFF;
        cyc();
        chk("rd_n6_ack", 64'(bus.wb_ack_o), 64'h0);
        chk("rd_n6_dat_hold", 64'(bus.wb_dat_o), 64'h12345678);

        // Illegal byte selects terminate with err and no AHB transfer
        for (int i = 0; i < 3; i++) begin
            req(1'b1, 64'h180, bad_sel[i], 32'h0);
            cyc();
            chk($sformatf("bad%0d_err", i), 64'(bus.wb_err_o), 64'h1);
            chk($sformatf("bad%0d_ack", i), 64'(bus.wb_ack_o), 64'h0);
            chk($sformatf("bad%0d_htrans", i), 64'(bus.HTRANS), 64'h0);
            chk($sformatf("bad%0d_hsel", i), 64'(bus.HSEL), 64'h0);
            release_bus();
            cyc();
            chk($sformatf("bad%0d_err_off", i), 64'(bus.wb_err_o), 64'h0);
            chk($sformatf("bad%0d_htrans_off", i), 64'(bus.HTRANS), 64'h0);
        end

        // Two-cycle AHB ERROR response on a write
        req(1'b1, 64'h200, 4'b1111, 32'h55AA55AA);
        cyc();
        chk("er_n1_htrans", 64'(bus.HTRANS), 64'h2);
        cyc();
        chk("er_n2_hwdata", 64'(bus.HWDATA), 64'h55AA55AA);
        bus.HREADY = 1'b0;
        bus.HRESP  = 1'b1;
        cyc();
        chk("er_n3_ack", 64'(bus.wb_ack_o), 64'h0);
        chk("er_n3_err", 64'(bus.wb_err_o), 64'h0);
        bus.HREADY = 1'b1;
        cyc();
        chk("er_n4_err", 64'(bus.wb_err_o), 64'h1);
        chk("er_n4_ack", 64'(bus.wb_ack_o), 64'h0);
        release_bus();
        bus.HRESP = 1'b0;
        cyc();
        chk("er_n5_err", 64'(bus.wb_err_o), 64'h0);
        chk("er_n5_ack", 64'(bus.wb_ack_o), 64'h0);

        // cyc dropped during the data phase, then a new byte write
        bus.HRDATA = 32'hAAAAAAAA;
        req(1'b0, 64'h240, 4'b0001, 32'h0);
        cyc();
        chk("ab_n1_htrans", 64'(bus.HTRANS), 64'h2);
        chk("ab_n1_hsize", 64'(bus.HSIZE), 64'h0);
        chk("ab_n1_haddr", bus.HADDR, 64'h240);
        cyc();
        chk("ab_n2_htrans", 64'(bus.HTRANS), 64'h0);
        release_bus();
        cyc();
        chk("ab_n3_ack", 64'(bus.wb_ack_o), 64'h0);
        chk("ab_n3_err", 64'(bus.wb_err_o), 64'h0);
        req(1'b1, 64'h303, 4'b0010, 32'h0000BB00);
        cyc();
        chk("nx_n1_htrans", 64'(bus.HTRANS), 64'h2);
        chk("nx_n1_haddr", bus.HADDR, 64'h301);
        chk("nx_n1_hsize", 64'(bus.HSIZE), 64'h0);
        cyc();
        chk("nx_n2_hwdata", 64'(bus.HWDATA), 64'h0000BB00);
        cyc();
        chk("nx_n3_ack", 64'(bus.wb_ack_o), 64'h1);
        release_bus();
        cyc();
        chk("nx_n4_ack", 64'(bus.wb_ack_o), 64'h0);

        // Reset during a stalled address phase
        req(1'b0, 64'h400, 4'b1111, 32'h0);
        cyc();
        chk("rs_n1_htrans", 64'(bus.HTRANS), 64'h2);
        bus.HREADY = 1'b0;
        cyc();
        chk("rs_n2_htrans_stall", 64'(bus.HTRANS), 64'h2);
        chk("rs_n2_hsel_stall", 64'(bus.HSEL), 64'h1);
        HRESET = 1'b1;
        #1;
        chk("rs_async_htrans", 64'(bus.HTRANS), 64'h0);
        chk("rs_async_hsel", 64'(bus.HSEL), 64'h0);
        chk("rs_async_haddr", bus.HADDR, 64'h0);
        chk("rs_async_dat", 64'(bus.wb_dat_o), 64'h0);
        release_bus();
        cyc();
        HRESET     = 1'b0;
        bus.HREADY = 1'b1;
        chk("rs_ack", 64'(bus.wb_ack_o), 64'h0);
        chk("rs_err", 64'(bus.wb_err_o), 64'h0);
        cyc();
        chk("rs_idle_ack", 64'(bus.wb_ack_o), 64'h0);
        bus.HRDATA = 32'hCAFEF00D;
        req(1'b0, 64'h500, 4'b1111, 32'h0);
        cyc();
        chk("pr_n1_htrans", 64'(bus.HTRANS), 64'h2);
        chk("pr_n1_haddr", bus.HADDR, 64'h500);
        cyc();
        chk("pr_n2_ack", 64'(bus.wb_ack_o), 64'h0);
        cyc();
        chk("pr_n3_ack", 64'(bus.wb_ack_o), 64'h1);
        chk("pr_n3_dat", 64'(bus.wb_dat_o), 64'hCAFEF00D);
        release_bus();
        cyc();
        chk("pr_n4_ack", 64'(bus.wb_ack_o), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mpsoc_wb2ahb_bridge.md
MPSOC_WB2AHB_BRIDGE -- requirements
Module: mpsoc_wb2ahb_bridge

Interface
REQ-001 Parameter HADDR_SIZE, default 64, SHALL set the Wishbone and AHB address width in bits.
REQ-002 Parameter HDATA_SIZE, default 32, SHALL set the data width; legal values are 32 or 64; BE_SIZE = HDATA_SIZE/8.
REQ-003 One clock, HCLK; reset HRESET is asynchronous and active-high.
REQ-004 HCLK  in  1  sole clock, rising edge.
REQ-005 HRESET  in  1  asynchronous active-high reset.
REQ-006 wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  Wishbone classic cycle, strobe, write.
REQ-007 wb_adr_i  in  HADDR_SIZE  byte address; wb_dat_i  in  HDATA_SIZE  write data; wb_sel_i  in  BE_SIZE  byte selects.
REQ-008 wb_dat_o  out  HDATA_SIZE  read data; wb_ack_o, wb_err_o  out  1 each  termination.
REQ-009 HSEL, HWRITE, HMASTLOCK  out  1 each; HADDR  out  HADDR_SIZE; HWDATA  out  HDATA_SIZE.
REQ-010 HSIZE  out  3; HBURST  out  3; HPROT  out  4; HTRANS  out  2  AHB-Lite master controls.
REQ-011 HRDATA  in  HDATA_SIZE; HREADY  in  1; HRESP  in  1  AHB-Lite slave response (one MPRAM port).

Function
REQ-012 FSM SHALL have states IDLE, ADDR, DATA, RESP.
REQ-013 IDLE -> ADDR when wb_cyc_i & wb_stb_i with legal wb_sel_i; request fields are registered on that edge.
REQ-014 IDLE -> RESP with wb_err_o=1 and no AHB transfer when wb_cyc_i & wb_stb_i with illegal wb_sel_i.
REQ-015 Legal wb_sel_i: contiguous ones, count 1/2/4/8 (not above BE_SIZE), lowest set index a multiple of the count.
REQ-016 HSIZE = BYTE/HWORD/WORD/DWORD for count 1/2/4/8; HADDR = wb_adr_i with low log2(BE_SIZE) bits replaced by the lowest set sel index.
REQ-017 In ADDR: HSEL=1, HTRANS=NONSEQ, HBURST=SINGLE, HPROT=4'b0011, HMASTLOCK=0; HWRITE and HADDR from the registered request; stay while HREADY=0, -> DATA when HREADY=1.
REQ-018 In DATA: HTRANS=IDLE, HSEL=0; HWDATA = registered wb_dat_i, held until exit; stay while HREADY=0.
REQ-019 DATA with HREADY=1: latch HRDATA into wb_dat_o on reads, set wb_ack_o=~HRESP and wb_err_o=HRESP, -> RESP.
REQ-020 In RESP, wb_ack_o or wb_err_o SHALL be high for exactly one cycle, then -> IDLE; wb_stb_i is ignored in RESP.
REQ-021 Zero-wait latency: stb sampled at edge N, NONSEQ in cycle N+1, data phase N+2, ack in N+3; each HREADY-low cycle adds one.
REQ-022 wb_cyc_i falling while in ADDR or DATA SHALL NOT abort the AHB transfer; it completes normally and ack/err are suppressed.
REQ-023 wb_dat_o SHALL hold its last value outside RESP; at most one transfer is outstanding.
REQ-024 The AHB master SHALL NOT issue SEQ, BUSY, or burst transfers.

Reset
REQ-025 On HRESET: state=IDLE; HSEL=0, HTRANS=IDLE, HWRITE=0, HADDR=0, HWDATA=0, HSIZE=0, HBURST=SINGLE, HPROT=4'b0011, HMASTLOCK=0, wb_ack_o=0, wb_err_o=0, wb_dat_o=0.
REQ-026 Reset asserted mid-transfer SHALL force the reset values immediately; no ack or err is issued for the aborted request.

Structure
REQ-027 HTRANS, HSIZE, HBURST, and HRESP encodings SHALL come from the shared mpsoc_pkg; the bridge defines no local encodings.
REQ-028 Sel-to-HSIZE/offset decode SHALL be the combinational sub-module mpsoc_wb2ahb_sel_decode, which outputs size, offset, and illegal.

Verification
REQ-029 HDATA_SIZE=32, write adr=0x100, sel=4'b1111, dat=0xDEADBEEF, HREADY=1 -> NONSEQ WORD HADDR=0x100 in N+1, HWDATA=0xDEADBEEF in N+2, ack in N+3.
REQ-030 Read adr=0x104, sel=4'b1100, slave returns 0x12345678 after 2 wait states -> HSIZE=HWORD, HADDR=0x106, ack in N+5, wb_dat_o=0x12345678.
REQ-031 sel=4'b0101 -> no NONSEQ issued, wb_err_o pulses in N+1.
REQ-032 Write, slave HRESP=ERROR with two-cycle response -> wb_err_o=1 for one cycle, wb_ack_o stays 0.
REQ-033 wb_cyc_i dropped in the DATA cycle -> transfer completes on AHB, no ack; a new request is accepted next IDLE cycle.
REQ-034 HRESET pulsed during ADDR with HREADY=0 -> HTRANS=IDLE at once, no ack; a subsequent read completes normally.
